// File: rtl/vote_tally.sv
// Voting-machine front end: debounces the arm and candidate buttons, allows one vote per arm, and keeps a saturating 4-digit BCD tally per candidate.
// Debounce takes DEBOUNCE_TICKS tick samples, the rise is registered one cycle later, and the selected tally is muxed to the digits combinationally.
module vote_tally #(
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_arm,
  input  logic [3:0] btn_cand,
  input  logic [1:0] sel,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       ready,
  output logic       voted,
  output logic       err_multi
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_TICKS);

  localparam logic [1:0] ST_LOCKED  = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAST    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Bit 0 is the arm button; bits 4:1 are candidates 0..3.
  logic [4:0]      raw_in;
  logic [4:0]      db_q, db_d;
  logic [4:0]      rise_q, rise_d;
  logic [4:0][7:0] cnt_q, cnt_d;

  logic [1:0]           state_q, state_d;
  logic [1:0]           cand_sel_q, cand_sel_d;
  logic                 err_multi_q, err_multi_d;
  logic [3:0][3:0][3:0] tally_q, tally_d;

  logic       arm_rise;
  logic [3:0] cand_rise;
  logic [3:0] cand_db;
  logic       cand_multi;
  logic       cand_one;
  logic [1:0] cand_idx;

  assign raw_in = {btn_cand, btn_arm};

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (tick) begin
        if (raw_in[i] != db_q[i]) begin
          if (cnt_q[i] + 8'd1 == DB_LIMIT) begin
            db_d[i]  = ~db_q[i];
            cnt_d[i] = 8'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end else begin
          cnt_d[i] = 8'd0;
        end
      end
    end
    rise_d = db_d & ~db_q;
  end

  assign arm_rise   = rise_q[0];
  assign cand_rise  = rise_q[4:1];
  assign cand_db    = db_q[4:1];
  assign cand_multi = (cand_rise & (cand_rise - 4'd1)) != 4'd0;
  assign cand_one   = (cand_rise != 4'd0) && !cand_multi;

  always_comb begin
    cand_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand_rise[i]) begin
        cand_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_sel_d  = cand_sel_q;
    err_multi_d = err_multi_q;
    case (state_q)
      ST_LOCKED: begin
        if (arm_rise) begin
          state_d     = ST_ARMED;
          err_multi_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (cand_multi) begin
          err_multi_d = 1'b1;
        end else if (cand_one) begin
          state_d    = ST_CAST;
          cand_sel_d = cand_idx;
        end
      end
      ST_CAST: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (cand_db == 4'd0) begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  // Decimal ripple increment that sticks at 9999.
  function automatic logic [3:0][3:0] bcd_inc(input logic [3:0][3:0] v);
    logic [3:0][3:0] r;
    logic            carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (v[d] >= 4'd9) begin
            r[d] = 4'd0;
          end else begin
            r[d]  = v[d] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    tally_d = tally_q;
    if (state_q == ST_CAST) begin
      tally_d[cand_sel_q] = bcd_inc(tally_q[cand_sel_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q        <= '0;
      rise_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_LOCKED;
      cand_sel_q  <= 2'd0;
      err_multi_q <= 1'b0;
      tally_q     <= '0;
    end else begin
      db_q        <= db_d;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      cand_sel_q  <= cand_sel_d;
      err_multi_q <= err_multi_d;
      tally_q     <= tally_d;
    end
  end

  assign ready     = (state_q == ST_ARMED);
  assign voted     = (state_q == ST_CAST);
  assign err_multi = err_multi_q;

  assign digit0 = tally_q[sel][0];
  assign digit1 = tally_q[sel][1];
  assign digit2 = tally_q[sel][2];
  assign digit3 = tally_q[sel][3];

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally: randomized button sequences against a count-per-candidate model,
// plus a fast-debounce instance driven through 10000 votes to reach saturation.
module tb_vote_tally;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst, tick, btn_arm;
  logic [3:0] btn_cand;
  logic [1:0] sel;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       ready, voted, err_multi;
  logic [15:0] digits;

  logic       rst_f, tick_f, arm_f;
  logic [3:0] cand_f;
  logic [1:0] sel_f;
  logic [3:0] fd0, fd1, fd2, fd3;
  logic       ready_f, voted_f, err_f;
  logic [15:0] digits_f;

  assign digits   = {digit3, digit2, digit1, digit0};
  assign digits_f = {fd3, fd2, fd1, fd0};

  vote_tally #(.DEBOUNCE_TICKS(D)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_arm(btn_arm), .btn_cand(btn_cand), .sel(sel),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .ready(ready), .voted(voted), .err_multi(err_multi)
  );

  vote_tally #(.DEBOUNCE_TICKS(1)) u_fast (
    .clk(clk), .rst(rst_f), .tick(tick_f), .btn_arm(arm_f), .btn_cand(cand_f), .sel(sel_f),
    .digit0(fd0), .digit1(fd1), .digit2(fd2), .digit3(fd3),
    .ready(ready_f), .voted(voted_f), .err_multi(err_f)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected vote responses: chk=0 means the pulse is expected but the count is not (reset follows).
  typedef struct packed {
    logic        chk;
    logic [15:0] bcd;
  } exp_t;
  exp_t        q_main[$];
  logic [15:0] q_fast[$];

  // Reference model: plain integer counts and an armed/error flag.
  int m_cnt[4];
  bit m_armed;
  bit m_err;
  int f_cnt;
  bit tick_dense = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic int sat_inc(input int n);
    return (n < 9999) ? n + 1 : 9999;
  endfunction

  initial begin
    tick = 1'b1;
    forever begin
      @(negedge clk);
      tick = tick_dense ? 1'b1 : 1'($urandom_range(0, 2) == 0);
    end
  end

  initial begin : mon_main
    exp_t e;
    forever begin
      @(negedge clk);
      if (voted) begin
        chk("vote_expected", 32'(q_main.size() != 0), 32'd1);
        chk("ready_low_in_cast", 32'(ready), 32'd0);
        if (q_main.size() != 0) begin
          e = q_main.pop_front();
          @(negedge clk);
          chk("voted_one_cycle", 32'(voted), 32'd0);
          if (e.chk) chk("tally_after_vote", 32'(digits), 32'(e.bcd));
        end
      end
    end
  end

  initial begin : mon_fast
    logic [15:0] eb;
    forever begin
      @(negedge clk);
      if (voted_f) begin
        chk("fast_vote_expected", 32'(q_fast.size() != 0), 32'd1);
        if (q_fast.size() != 0) begin
          eb = q_fast.pop_front();
          @(negedge clk);
          chk("fast_tally_after_vote", 32'(digits_f), 32'(eb));
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    @(negedge clk);
  endtask

  task automatic sweep();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("digits_sel%0d", s), 32'(digits), 32'(to_bcd(m_cnt[s])));
    end
  endtask

  task automatic check_status();
    chk("ready", 32'(ready), 32'(m_armed));
    chk("err_multi", 32'(err_multi), 32'(m_err));
  endtask

  task automatic press_arm();
    btn_arm = 1'b1;
    wait_ticks(D + int'($urandom_range(1, 4)));
    btn_arm = 1'b0;
    wait_ticks(D + 2);
    if (!m_armed) begin
      m_armed = 1'b1;
      m_err   = 1'b0;
    end
    check_status();
  endtask

  task automatic press_cands(input logic [3:0] mask);
    int c = 0;
    int nb = $countones(mask);
    for (int i = 3; i >= 0; i--) if (mask[i]) c = i;
    sel = 2'(c);
    if (m_armed && nb == 1) begin
      m_cnt[c] = sat_inc(m_cnt[c]);
      q_main.push_back({1'b1, to_bcd(m_cnt[c])});
      m_armed = 1'b0;
    end else if (m_armed && nb > 1) begin
      m_err = 1'b1;
    end
    btn_cand = mask;
    wait_ticks(D + int'($urandom_range(1, 5)));
    btn_cand = 4'd0;
    wait_ticks(D + 3);
    check_status();
    sweep();
  endtask

  // First candidate votes; a second one pressed while the first is still held must not count.
  task automatic press_overlap(input int a, input int b);
    sel = 2'(a);
    if (m_armed) begin
      m_cnt[a] = sat_inc(m_cnt[a]);
      q_main.push_back({1'b1, to_bcd(m_cnt[a])});
      m_armed = 1'b0;
    end
    btn_cand[a] = 1'b1;
    wait_ticks(D + 3);
    btn_cand[b] = 1'b1;
    wait_ticks(D + 3);
    btn_cand = 4'd0;
    wait_ticks(D + 3);
    check_status();
    sweep();
  endtask

  initial begin : stim
    bit got;
    int a, b, r;
    rst = 1'b1; rst_f = 1'b1;
    btn_arm = 1'b0; btn_cand = 4'd0; sel = 2'd0;
    tick_f = 1'b1; arm_f = 1'b0; cand_f = 4'd0; sel_f = 2'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_armed = 1'b0; m_err = 1'b0; f_cnt = 0;
    repeat (3) @(negedge clk);
    sweep();
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_voted", 32'(voted), 32'd0);
    chk("reset_err", 32'(err_multi), 32'd0);
    rst = 1'b0; rst_f = 1'b0;
    @(negedge clk);
    check_status();

    // Basic vote, press while locked, press during release.
    press_arm();
    press_cands(4'b0100);
    press_cands(4'b0010);
    press_arm();
    press_overlap(1, 3);

    // Simultaneous candidates, ignored re-arm while armed, then error clear on accepted arm.
    press_arm();
    press_cands(4'b1001);
    press_arm();
    press_cands(4'b1000);
    press_arm();
    press_cands(4'b0001);

    // Bouncing candidate while armed.
    press_arm();
    sel = 2'd1;
    for (int i = 0; i < 10; i++) begin
      btn_cand[1] = ~btn_cand[1];
      wait_ticks(3);
    end
    btn_cand = 4'd0;
    wait_ticks(D + 2);
    check_status();
    sweep();
    press_cands(4'b0010);

    // Randomized sequences with sparse or continuous tick.
    for (int it = 0; it < 20; it++) begin
      tick_dense = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 8) press_arm();
      a = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        press_cands(4'(1 << a));
      end else if (r == 7) begin
        b = (a + 1 + int'($urandom_range(0, 2))) % 4;
        press_overlap(a, b);
      end else begin
        b = (a + 1 + int'($urandom_range(0, 2))) % 4;
        press_cands(4'((1 << a) | (1 << b)));
      end
    end
    tick_dense = 1'b1;
    if (m_armed) press_cands(4'b0001);

    // Reset while in CAST: pending increment dropped, machine back to LOCKED.
    press_arm();
    sel = 2'd2;
    q_main.push_back({1'b0, 16'h0000});
    btn_cand = 4'b0100;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (voted) got = 1'b1;
    end
    chk("vote_seen_before_reset", 32'(got), 32'd1);
    rst = 1'b1;
    btn_cand = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_armed = 1'b0; m_err = 1'b0;
    @(negedge clk);
    check_status();
    sweep();
    press_arm();
    press_cands(4'b0100);

    // Fast instance: 1009 votes (ripple 0999->1000), then to 9999, then one more.
    for (int v = 1; v <= 10000; v++) begin
      f_cnt = sat_inc(f_cnt);
      q_fast.push_back(to_bcd(f_cnt));
      arm_f = 1'b1;
      @(negedge clk);
      arm_f = 1'b0;
      cand_f = 4'b0001;
      @(negedge clk);
      cand_f = 4'b0000;
      repeat (3) @(negedge clk);
      if (v == 1009) chk("fast_count_1009", 32'(digits_f), 32'h1009);
      if (v == 9999) chk("fast_count_9999", 32'(digits_f), 32'h9999);
    end
    repeat (4) @(negedge clk);
    chk("fast_saturated", 32'(digits_f), 32'h9999);
    chk("fast_err_clear", 32'(err_f), 32'd0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q_main.size() + q_fast.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vote_tally.md
# vote_tally

Per-candidate vote capture and BCD tally for the voting machine. Debounces the four candidate push-buttons and the poll-worker arm button, and enforces one vote per arm through a small state machine. Keeps a four-digit saturating BCD count per candidate. Presents the selected candidate's digits to the downstream BCD-to-7-segment decoders, which in turn feed the four-digit display multiplexer.

## Interface

Parameters:
- DEBOUNCE_TICKS, default 8: number of consecutive `tick` samples a raw input must differ from its debounced value before the debounced value flips. Legal range 1..255.

Ports:
- clk  input  1  system clock (50 MHz board clock); all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle sample strobe from the clock divider (5 kHz nominal). Debouncers advance only on cycles with tick=1.
- btn_arm  input  1  raw poll-worker arm button, active high.
- btn_cand  input  4  raw candidate buttons, bit i = candidate i, active high.
- sel  input  2  candidate whose tally is driven on the digit outputs.
- digit0..digit3  output  4 each  BCD of the selected candidate's count: digit0 = ones, digit3 = thousands.
- ready  output  1  high while the FSM is in ARMED.
- voted  output  1  one-cycle pulse when a vote is committed.
- err_multi  output  1  sticky; set when more than one candidate rises in the same cycle while ARMED.

## Operation

Debounce, one instance per input (5 total):
- Each input has a stable register `db` and an 8-bit counter.
- On a tick cycle where raw ≠ db, the counter increments. When it reaches DEBOUNCE_TICKS, db flips and the counter clears.
- On a tick cycle where raw = db, the counter clears. Non-tick cycles hold everything.
- The rising edge of each db is registered: `rise[i]` is high for exactly one cycle, the cycle after db goes 0→1.

FSM, states LOCKED, ARMED, CAST, RELEASE:
- LOCKED → ARMED on arm_rise. Candidate rises are ignored in LOCKED.
- In ARMED, if exactly one candidate rise is present → CAST, latching the candidate index.
- In ARMED, two or more simultaneous candidate rises → stay ARMED, set err_multi, no count change.
- In ARMED, arm_rise is ignored.
- CAST lasts exactly one cycle. voted=1 and the latched candidate's count increments. Next state is RELEASE.
- RELEASE → LOCKED on the first cycle where all four debounced candidate inputs are 0. This includes the cycle right after CAST, if the buttons are already released.
- err_multi clears on the next arm_rise that is accepted (LOCKED→ARMED), or on rst.

Tally:
- Four candidates, each with four BCD digits.
- Increment is a decimal ripple: a digit at 9 wraps to 0 and carries into the next digit.
- Saturation: a count of 9999 stays 9999. No wrap to 0000, but voted still pulses.
- Digit values are always 0..9. Codes 10..15 never appear.

Display:
- digit0..3 are a combinational mux of the tally addressed by sel.

Reset:
- All counts 0000, FSM LOCKED, all db and counters 0, rise 0.
- ready=0, voted=0, err_multi=0. digitN=0 for any sel.
- Reset asserted during CAST discards the pending increment: the count is unchanged from the pre-CAST value, since the increment is written on the CAST→RELEASE edge and rst has priority.

## Timing

- Press latency: a raw press stable from tick k sets db at the edge of tick k+DEBOUNCE_TICKS−1. rise is high the following cycle, and the FSM leaves ARMED on that cycle's edge.
- voted is high during the CAST cycle. The tally register shows the new value from the next cycle (first RELEASE cycle).
- sel → digit change has zero-cycle latency, combinational.
- ready is a registered state decode. It rises the cycle after arm_rise and falls on the cycle CAST is entered.
- Bouncing raw input (toggling before DEBOUNCE_TICKS tick samples accumulate) produces no db change and no rise.
- tick held high continuously is legal; debounce then counts clk cycles.

## Test plan

- Reset with sel sweep 0..3: digits all 0, ready=0, err_multi=0.
- Arm (btn_arm held 8 ticks), then cand 2 held 8 ticks then released. Expect ready 1→0, one voted pulse. sel=2 reads 0001; sel=0,1,3 read 0000. FSM returns to LOCKED.
- Cand 1 pressed while LOCKED: no voted, count stays 0000. Second cand press in RELEASE without re-arm: no count.
- Arm, then cand 0 and cand 3 debounced in the same cycle: err_multi=1, ready stays 1, counts unchanged. Next arm_rise clears err_multi.
- Preload via 1009 arm/vote cycles on cand 0: reads 1009 after the ripple 0999→1000. Drive to 9999, vote once more: stays 9999, voted still pulses.
- Raw cand bounce (toggling every 3 ticks, DEBOUNCE_TICKS=8) while ARMED: no rise, no vote. rst asserted during CAST: count unchanged, state LOCKED.
